keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
4x4 matrix keypad front end that feeds the RPN stack. Drives one row at a time and synchronises the sense lines. Debounces one key press and emits a 5-bit key code with a single-cycle intro strobe. Runs on the serial clock domain used by the calculator; one strobe per physical press, no auto-repeat.

Parameters:
SETTLE_CYCLES, 4, cycles each row is driven before sense is sampled (must be >= 3 to cover the 2-flop synchroniser)
DEBOUNCE_CYCLES, 8, consecutive stable samples required for both press and release (>= 1)

Ports:
clk  input  1  block clock
rst  input  1  asynchronous, active-high reset
sense_pins  input  4  column inputs, externally pulled up; 0 = key closed on the driven row
drive_pins  output  4  row drives, active-low one-cold; exactly one bit is 0 at all times
value  output  5  key code of the last accepted key; held until the next accept
intro  output  1  one-cycle strobe; value is valid in the same cycle

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: drive_pins=4'b1110 (row 0), value=5'd0, intro=0, state=SCAN, row=0, all counters 0, synchroniser flops=4'b1111.
- Synchroniser: sense_pins pass through 2 flops giving sense_s. All decisions use sense_s only.
- SCAN:
  - Drive the current row low for SETTLE_CYCLES cycles.
  - On the last settle cycle, sample sense_s.
  - If any bit is 0: latch row and col, where col is the lowest-index 0 bit. Go to DEBOUNCE.
  - Else: advance row (3 wraps to 0), clear the settle counter, stay in SCAN.
- DEBOUNCE:
  - Keep the same row driven and check sense_s[col] every cycle.
  - Counter counts consecutive 0 samples. When the counter reaches DEBOUNCE_CYCLES, go to EMIT.
  - Any 1 sample: abandon, advance row, go to SCAN. No strobe.
- EMIT (1 cycle):
  - value <= decode(row,col), registered; intro=1 for exactly this cycle.
  - Next state is WAIT_RELEASE.
- WAIT_RELEASE:
  - Keep the row driven.
  - Counter counts consecutive cycles with sense_s == 4'b1111 on that row. Any 0 sample clears the counter.
  - When the counter reaches DEBOUNCE_CYCLES: advance row, go to SCAN.
  - No timeout; a held key blocks scanning indefinitely.
- Latency: pin edge to intro = sync delay + remaining settle + DEBOUNCE_CYCLES + 1.
  - Key already stable while its row is driven: intro rises exactly SETTLE_CYCLES+DEBOUNCE_CYCLES+1 cycles after that row was first driven.
- Simultaneous keys:
  - Same row: lowest column wins.
  - Different rows: first row reached in scan order wins.
  - Other keys pressed during WAIT_RELEASE are ignored and also delay release (sense_s must be all 1 on the held row).
- Key map (row, col -> code):
  - r0: 1, 2, 3, +
  - r1: 4, 5, 6, -
  - r2: 7, 8, 9, *
  - r3: C, 0, E, /
  - Digits -> 5'd0..5'd9, '+'=5'd16, '-'=5'd17, '*'=5'd18, '/'=5'd19, E(enter)=5'd20, C(clear)=5'd21. Codes 10-15 and 22-31 are never produced.
- Counter widths: sized by $clog2(max(SETTLE_CYCLES,DEBOUNCE_CYCLES)+1); no wrap is reachable.
- Reset mid-operation: asserting rst in any state returns to reset values immediately. A key held through reset produces exactly one strobe, after a full scan reaches it.

Decomposition:
- Shared package keypad_pkg:
  - state enum SCAN/DEBOUNCE/EMIT/WAIT_RELEASE
  - key code constants KEY_ADD=16, KEY_SUB=17, KEY_MUL=18, KEY_DIV=19, KEY_ENTER=20, KEY_CLEAR=21
  - the rows x cols geometry constants (4)
  - the rpn_stack consumes the same code constants.
- One combinational sub-module, keypad_decode: (row[1:0], col[1:0]) -> code[4:0]. Unit-tested separately.

Test Plan:
- Reset, no keys (sense=4'b1111), SETTLE=4, DEBOUNCE=8 -> drive_pins cycles 1110,1101,1011,0111 every 4 clk; intro never asserts.
- Hold key r1c2 ('6') stable -> intro exactly one cycle with value=5'd6, 13 cycles after drive_pins first equals 4'b1101; no second strobe while held.
- Glitch r0c3 low for 5 cycles (< DEBOUNCE) -> no intro; scan resumes at row 1. Then hold it for 20 cycles -> value=5'd16, single intro.
- Release bounce: after accepting r3c1 ('0'), toggle sense[1] 3 times at 2-cycle spacing, then release -> one intro only; SCAN resumes 8 cycles after the final release.
- Keys r2c0 and r2c2 together -> value=5'd7. Keys r0c1 and r3c3 together, row 0 scanned first -> value=5'd2.
- rst asserted during DEBOUNCE and again during WAIT_RELEASE -> outputs at reset values asynchronously. The held key is re-detected and strobes exactly once after the full scan.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: matrix geometry, scanner states and key codes.
// The RPN stack consumes the same key code constants.
package keypad_pkg;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned CODE_W = 5;

    localparam logic [1:0] SCAN         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] EMIT         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    localparam logic [CODE_W-1:0] KEY_ADD   = 5'd16;
    localparam logic [CODE_W-1:0] KEY_SUB   = 5'd17;
    localparam logic [CODE_W-1:0] KEY_MUL   = 5'd18;
    localparam logic [CODE_W-1:0] KEY_DIV   = 5'd19;
    localparam logic [CODE_W-1:0] KEY_ENTER = 5'd20;
    localparam logic [CODE_W-1:0] KEY_CLEAR = 5'd21;

    // Index of the lowest closed (0) column; only meaningful when some bit is 0.
    function automatic logic [COL_W-1:0] lowest_zero(input logic [COLS-1:0] s);
        logic [COL_W-1:0] idx;
        idx = COL_W'(COLS - 1);
        for (int i = int'(COLS) - 1; i >= 0; i--) begin
            if (!s[i]) idx = COL_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational key map: (row, col) of the 4x4 matrix to a 5-bit key code.
module keypad_decode
    import keypad_pkg::*;
(
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [CODE_W-1:0] code
);

    always_comb begin
        code = '0;
        case ({row, col})
            4'h0: code = 5'd1;
            4'h1: code = 5'd2;
            4'h2: code = 5'd3;
            4'h3: code = KEY_ADD;
            4'h4: code = 5'd4;
            4'h5: code = 5'd5;
            4'h6: code = 5'd6;
            4'h7: code = KEY_SUB;
            4'h8: code = 5'd7;
            4'h9: code = 5'd8;
            4'hA: code = 5'd9;
            4'hB: code = KEY_MUL;
            4'hC: code = KEY_CLEAR;
            4'hD: code = 5'd0;
            4'hE: code = KEY_ENTER;
            4'hF: code = KEY_DIV;
            default: code = '0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad front end: one-cold row scan, 2-flop sense synchroniser,
// press/release debounce and a single-cycle intro strobe per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES   = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   sense_pins,
    output logic [ROWS-1:0]   drive_pins,
    output logic [CODE_W-1:0] value,
    output logic              intro
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [COLS-1:0]   sense_meta;
    logic [COLS-1:0]   sense_s;
    logic [1:0]        state,   state_d;
    logic [ROW_W-1:0]  row,     row_d;
    logic [COL_W-1:0]  col,     col_d;
    logic [CNT_W-1:0]  cnt,     cnt_d;
    logic [CODE_W-1:0] value_d;
    logic              intro_d;
    logic [ROWS-1:0]   drive_d;
    logic [CODE_W-1:0] code;

    keypad_decode u_decode (
        .row  (row),
        .col  (col),
        .code (code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sense_meta <= '1;
            sense_s    <= '1;
            state      <= SCAN;
            row        <= '0;
            col        <= '0;
            cnt        <= '0;
            drive_pins <= 4'b1110;
            value      <= '0;
            intro      <= 1'b0;
        end else begin
            sense_meta <= sense_pins;
            sense_s    <= sense_meta;
            state      <= state_d;
            row        <= row_d;
            col        <= col_d;
            cnt        <= cnt_d;
            drive_pins <= drive_d;
            value      <= value_d;
            intro      <= intro_d;
        end
    end

    // Row advance wraps naturally through the 2-bit row register.
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        cnt_d   = cnt;
        value_d = value;
        intro_d = 1'b0;
        case (state)
            SCAN: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (sense_s != '1) begin
                        col_d   = lowest_zero(sense_s);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row + ROW_W'(1);
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (!sense_s[col]) begin
                    if (cnt == DEB_LAST) begin
                        cnt_d   = '0;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    row_d   = row + ROW_W'(1);
                    state_d = SCAN;
                end
            end
            EMIT: begin
                value_d = code;
                intro_d = 1'b1;
                cnt_d   = '0;
                state_d = WAIT_RELEASE;
            end
            WAIT_RELEASE: begin
                // Any closed contact on the held row restarts the release count.
                if (sense_s == '1) begin
                    if (cnt == DEB_LAST) begin
                        cnt_d   = '0;
                        row_d   = row + ROW_W'(1);
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase
        drive_d = ~(ROWS'(1) << row_d);
    end

endmodule
